// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, requester ownership, counter width.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WS   = 3'd2,
    ST_WP   = 3'd3,
    ST_WH   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_VPU = 1'b1
  } owner_t;

  localparam int CNT_W = 8;

  // Chip enable and the lane strobe are asserted in every state that touches the SRAM.
  function automatic logic strobe_active(input state_t s);
    return (s == ST_RD) || (s == ST_WS) || (s == ST_WP) || (s == ST_WH);
  endfunction

endpackage

// File: rtl/sram_arbiter_byte_lane.sv
// Byte-lane steering between an 8-bit requester and the 16-bit SRAM bus.
// Purely combinational; the arbiter registers everything it drives off-chip.
module sram_arbiter_byte_lane (
  input  logic        i_sel_hi,
  input  logic [15:0] i_dq,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata,
  output logic        o_ub_n,
  output logic        o_lb_n,
  output logic [15:0] o_dq
);

  assign o_rdata = i_sel_hi ? i_dq[15:8] : i_dq[7:0];
  assign o_ub_n  = ~i_sel_hi;
  assign o_lb_n  = i_sel_hi;
  assign o_dq    = {i_wdata, i_wdata};

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the shared 16-bit async SRAM between the CPU byte port and the VPU fetch port,
// producing registered strobes and byte-lane steering.
//
// state | meaning
// IDLE  | sample requests, latch owner/addr/wdata, pick the next access
// RD    | ce_n/oe_n/lane low for RD_CYCLES; read byte captured at the last edge
// WS    | write setup: ce_n/lane low, data driven, we_n high
// WP    | write pulse: we_n low for WR_CYCLES
// WH    | write hold: we_n high, data still driven
// DONE  | all strobes released; vid_ack pulse or CPU hold release
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 21,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2,
  parameter bit VPU_PRIO  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_rw,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_cpu_hold,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [7:0]        o_vid_rdata,
  output logic              o_vid_ack,
  output logic [ADDR_W-2:0] o_sram_addr,
  output logic [15:0]       o_sram_dq_o,
  output logic              o_sram_dq_oe,
  input  logic [15:0]       i_sram_dq_i,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  owner_t             r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [7:0]         r_wdata, w_wdata_nxt;
  logic               r_last_vpu, w_grant, w_cap;
  logic               w_cpu_win, w_vid_win, w_active_nxt;
  logic [7:0]         r_cpu_rdata, r_vid_rdata, w_lane_rdata;
  logic               r_vid_ack;
  logic               r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n, r_dq_oe;
  logic [15:0]        r_dq_o, w_dq_o;
  logic               w_ub_n, w_lb_n;

  // A VPU grant last time hands the next contested slot to the CPU.
  assign w_cpu_win = i_cpu_req && (!i_vid_req || !VPU_PRIO || r_last_vpu);
  assign w_vid_win = i_vid_req && !w_cpu_win;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_grant     = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_win) begin
          w_grant     = 1'b1;
          w_owner_nxt = OWNER_CPU;
          w_addr_nxt  = i_cpu_addr;
          w_wdata_nxt = i_cpu_wdata;
          w_state_nxt = i_cpu_rw ? ST_RD : ST_WS;
          w_cnt_nxt   = RD_LOAD;
        end else if (w_vid_win) begin
          w_grant     = 1'b1;
          w_owner_nxt = OWNER_VPU;
          w_addr_nxt  = i_vid_addr;
          w_state_nxt = ST_RD;
          w_cnt_nxt   = RD_LOAD;
        end
      end
      ST_RD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
          w_cap       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_WS: begin
        w_state_nxt = ST_WP;
        w_cnt_nxt   = WR_LOAD;
      end
      ST_WP: begin
        if (r_cnt == '0) w_state_nxt = ST_WH;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_WH:   w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_active_nxt = strobe_active(w_state_nxt);

  // Lane decode follows the next address so strobes land on the same edge as the state.
  sram_arbiter_byte_lane u_lane (
    .i_sel_hi (w_addr_nxt[0]),
    .i_dq     (i_sram_dq_i),
    .i_wdata  (w_wdata_nxt),
    .o_rdata  (w_lane_rdata),
    .o_ub_n   (w_ub_n),
    .o_lb_n   (w_lb_n),
    .o_dq     (w_dq_o)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWNER_CPU;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_last_vpu  <= 1'b0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
      r_vid_ack   <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_o      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      if (w_grant) r_last_vpu <= (w_owner_nxt == OWNER_VPU);
      if (w_cap) begin
        if (r_owner == OWNER_CPU) r_cpu_rdata <= w_lane_rdata;
        else                      r_vid_rdata <= w_lane_rdata;
      end
      r_vid_ack <= (w_state_nxt == ST_DONE) && (w_owner_nxt == OWNER_VPU);
      r_ce_n    <= ~w_active_nxt;
      r_oe_n    <= ~(w_state_nxt == ST_RD);
      r_we_n    <= ~(w_state_nxt == ST_WP);
      r_ub_n    <= w_active_nxt ? w_ub_n : 1'b1;
      r_lb_n    <= w_active_nxt ? w_lb_n : 1'b1;
      r_dq_oe   <= (w_state_nxt == ST_WS) || (w_state_nxt == ST_WP) || (w_state_nxt == ST_WH);
      r_dq_o    <= w_dq_o;
    end
  end

  assign o_cpu_hold   = i_cpu_req && !((r_state == ST_DONE) && (r_owner == OWNER_CPU)) && !i_rst;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_vid_rdata  = r_vid_rdata;
  assign o_vid_ack    = r_vid_ack;
  assign o_sram_addr  = r_addr[ADDR_W-1:1];
  assign o_sram_dq_o  = r_dq_o;
  assign o_sram_dq_oe = r_dq_oe;
  assign o_sram_ce_n  = r_ce_n;
  assign o_sram_oe_n  = r_oe_n;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_ub_n  = r_ub_n;
  assign o_sram_lb_n  = r_lb_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter against a small async SRAM model.
module tb_sram_arbiter;

  localparam int ADDR_W = 21;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_rw = 1'b1;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_wdata = '0;
  logic [7:0]        cpu_rdata;
  logic              cpu_hold;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic [7:0]        vid_rdata;
  logic              vid_ack;
  logic [ADDR_W-2:0] sram_addr;
  logic [15:0]       sram_dq_o, sram_dq_i;
  logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(ADDR_W), .RD_CYCLES(2), .WR_CYCLES(2), .VPU_PRIO(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_rw(cpu_rw), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_hold(cpu_hold),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_rdata(vid_rdata), .o_vid_ack(vid_ack),
    .o_sram_addr(sram_addr), .o_sram_dq_o(sram_dq_o), .o_sram_dq_oe(sram_dq_oe),
    .i_sram_dq_i(sram_dq_i),
    .o_sram_ce_n(sram_ce_n), .o_sram_oe_n(sram_oe_n), .o_sram_we_n(sram_we_n),
    .o_sram_ub_n(sram_ub_n), .o_sram_lb_n(sram_lb_n)
  );

  // SRAM model: 1K words, known fill, writes on negedges while we_n is low.
  logic [15:0] mem [0:1023];
  bit          mem_inited = 1'b0;
  int          overlap_cnt = 0, tran_err_cnt = 0, ack_total = 0, ack_double = 0;
  logic        prev_ack = 1'b0, prev_oe_low = 1'b0, prev_dqoe = 1'b0;

  function automatic logic [15:0] fill_word(input int w);
    if (w == 128) return 16'hA55A;
    if (w == 256) return 16'h7E11;
    return {8'(w * 7 + 3), 8'(w * 13 + 1)};
  endfunction

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

  always @(negedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) mem[i] = fill_word(i);
      mem_inited = 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  = sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_addr[9:0]][15:8] = sram_dq_o[15:8];
    end
    if (!sram_oe_n && sram_dq_oe) overlap_cnt++;
    if ((!sram_oe_n && prev_dqoe) || (sram_dq_oe && prev_oe_low)) tran_err_cnt++;
    if (vid_ack) begin
      ack_total++;
      if (prev_ack) ack_double++;
    end
    prev_ack    = vid_ack;
    prev_oe_low = !sram_oe_n;
    prev_dqoe   = sram_dq_oe;
  end

  // Runs one CPU access and measures strobe activity; no checks of its own.
  task automatic cpu_xfer(input logic rw, input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                          output int hold_c, output int oe_c, output int we_c, output int we_out,
                          output int dqoe_c, output int ub_c, output int lb_c,
                          output logic [ADDR_W-2:0] saddr, output bit tmo);
    hold_c = 0; oe_c = 0; we_c = 0; we_out = 0; dqoe_c = 0; ub_c = 0; lb_c = 0;
    saddr = '1; tmo = 1'b1;
    @(posedge clk); #1;
    cpu_rw = rw; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cpu_hold) begin
        tmo = 1'b0;
        break;
      end
      hold_c++;
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) begin
        we_c++;
        if (!sram_dq_oe) we_out++;
      end
      if (sram_dq_oe) dqoe_c++;
      if (!sram_ub_n) ub_c++;
      if (!sram_lb_n) lb_c++;
      if (!sram_ce_n) saddr = sram_addr;
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_strobes: got %b want 11111",
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    checks++;
    if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe: got %b want 0", sram_dq_oe); end
    checks++;
    if (vid_ack !== 1'b0) begin errors++; $display("FAIL reset_vid_ack: got %b want 0", vid_ack); end
    checks++;
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", cpu_hold); end
    checks++;
    if (cpu_rdata !== 8'h00 || vid_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h/%h want 00/00", cpu_rdata, vid_rdata);
    end
    checks++;
    if (sram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    int hc, oc, wc, wo, dc, uc, lc;
    logic [ADDR_W-2:0] sa;
    bit tmo;
    cpu_xfer(1'b1, 21'h000101, 8'h00, hc, oc, wc, wo, dc, uc, lc, sa, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL read_timeout: hold never dropped"); end
    checks++;
    if (hc != 3) begin errors++; $display("FAIL read_hold_cycles: got %0d want 3", hc); end
    checks++;
    if (oc != 2) begin errors++; $display("FAIL read_oe_cycles: got %0d want 2", oc); end
    checks++;
    if (uc != 2 || lc != 0) begin errors++; $display("FAIL read_lanes: ub %0d lb %0d want 2 0", uc, lc); end
    checks++;
    if (sa !== 20'h00080) begin errors++; $display("FAIL read_word_addr: got %h want 00080", sa); end
    checks++;
    if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", cpu_rdata); end
  endtask

  task automatic test_cpu_write();
    int hc, oc, wc, wo, dc, uc, lc;
    logic [ADDR_W-2:0] sa;
    bit tmo;
    cpu_xfer(1'b0, 21'h000200, 8'h22, hc, oc, wc, wo, dc, uc, lc, sa, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL write_timeout: hold never dropped"); end
    checks++;
    if (hc != 5) begin errors++; $display("FAIL write_hold_cycles: got %0d want 5", hc); end
    checks++;
    if (wc != 2 || wo != 0) begin
      errors++; $display("FAIL write_we_pulse: low %0d outside %0d want 2 0", wc, wo);
    end
    checks++;
    if (dc != 4) begin errors++; $display("FAIL write_dq_oe_cycles: got %0d want 4", dc); end
    checks++;
    if (lc != 4 || uc != 0) begin errors++; $display("FAIL write_lanes: lb %0d ub %0d want 4 0", lc, uc); end
    checks++;
    if (oc != 0) begin errors++; $display("FAIL write_oe: got %0d want 0", oc); end
    checks++;
    if (sa !== 20'h00100) begin errors++; $display("FAIL write_word_addr: got %h want 00100", sa); end
    checks++;
    if (mem[256] !== 16'h7E22) begin errors++; $display("FAIL write_mem: got %h want 7e22", mem[256]); end
  endtask

  task automatic test_arbitration();
    int seq [3];
    int n = 0, nv = 0;
    logic [7:0] got_v [2];
    logic [7:0] got_c = 8'h00;
    seq[0] = 0; seq[1] = 0; seq[2] = 0;
    got_v[0] = 8'h00; got_v[1] = 8'h00;
    @(posedge clk); #1;
    cpu_rw = 1'b1; cpu_addr = 21'h000033; cpu_req = 1'b1;
    vid_addr = 21'h000044; vid_req = 1'b1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (vid_ack) begin
        seq[n] = 1;
        if (nv < 2) got_v[nv] = vid_rdata;
        nv++; n++;
        vid_addr = 21'h000047;
        if (n == 3) vid_req = 1'b0;
      end else if (cpu_req && !cpu_hold) begin
        seq[n] = 2; got_c = cpu_rdata; n++;
        cpu_req = 1'b0;
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    checks++;
    if (n != 3) begin errors++; $display("FAIL arb_timeout: events %0d want 3", n); end
    checks++;
    if (seq[0] != 1 || seq[1] != 2 || seq[2] != 1) begin
      errors++; $display("FAIL arb_order: got %0d %0d %0d want 1 2 1 (1=vpu 2=cpu)", seq[0], seq[1], seq[2]);
    end
    checks++;
    if (got_v[0] !== mem[10'h022][7:0]) begin
      errors++; $display("FAIL arb_vid0_data: got %h want %h", got_v[0], mem[10'h022][7:0]);
    end
    checks++;
    if (got_c !== mem[10'h019][15:8]) begin
      errors++; $display("FAIL arb_cpu_data: got %h want %h", got_c, mem[10'h019][15:8]);
    end
    checks++;
    if (got_v[1] !== mem[10'h023][15:8]) begin
      errors++; $display("FAIL arb_vid1_data: got %h want %h", got_v[1], mem[10'h023][15:8]);
    end
  endtask

  task automatic test_vpu_stream();
    int start_ack, fetches = 0, cyc = 0;
    logic [ADDR_W-1:0] a = '0;
    logic [7:0] exp;
    @(posedge clk); #1;
    start_ack = ack_total;
    vid_addr = a; vid_req = 1'b1;
    while (fetches < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (vid_ack) begin
        exp = a[0] ? mem[a[10:1]][15:8] : mem[a[10:1]][7:0];
        checks++;
        if (vid_rdata !== exp) begin
          errors++; $display("FAIL stream_data[%0d]: got %h want %h", fetches, vid_rdata, exp);
        end
        fetches++;
        a = a + 1'b1;
        vid_addr = a;
        if (fetches == 100) vid_req = 1'b0;
      end
    end
    vid_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (fetches != 100) begin errors++; $display("FAIL stream_count: got %0d want 100", fetches); end
    checks++;
    if (cyc != 400) begin errors++; $display("FAIL stream_cycles: got %0d want 400", cyc); end
    checks++;
    if (ack_total - start_ack != 100) begin
      errors++; $display("FAIL stream_acks: got %0d want 100", ack_total - start_ack);
    end
    checks++;
    if (ack_double != 0) begin errors++; $display("FAIL ack_width: got %0d long pulses want 0", ack_double); end
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL oe_dq_overlap: got %0d want 0", overlap_cnt); end
    checks++;
    if (tran_err_cnt != 0) begin errors++; $display("FAIL oe_dq_gap: got %0d want 0", tran_err_cnt); end
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    int start_ack, ce_low = 0;
    @(posedge clk); #1;
    cpu_rw = 1'b0; cpu_addr = 21'h000300; cpu_wdata = 8'h5C; cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!sram_we_n) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_wp_reach: we_n never low"); end
    rst = 1'b1;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL rst_async_release: we_n %b dq_oe %b want 1 0", sram_we_n, sram_dq_oe);
    end
    checks++;
    if (sram_ce_n !== 1'b1 || sram_lb_n !== 1'b1) begin
      errors++; $display("FAIL rst_async_ce: ce_n %b lb_n %b want 1 1", sram_ce_n, sram_lb_n);
    end
    checks++;
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b want 0", cpu_hold); end
    checks++;
    if (cpu_rdata !== 8'h00 || vid_rdata !== 8'h00 || sram_addr !== '0) begin
      errors++; $display("FAIL rst_regs: rdata %h/%h addr %h want 00/00/0", cpu_rdata, vid_rdata, sram_addr);
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    start_ack = ack_total;
    repeat (6) begin
      @(negedge clk);
      if (!sram_ce_n) ce_low++;
    end
    @(posedge clk); #1;
    checks++;
    if (ce_low != 0) begin errors++; $display("FAIL rst_idle: ce_n low %0d cycles want 0", ce_low); end
    checks++;
    if (ack_total != start_ack) begin
      errors++; $display("FAIL rst_no_ack: got %0d acks want 0", ack_total - start_ack);
    end
  endtask

  task automatic test_cpu_drop();
    int start_ack, ce_low = 0, hold_hi = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    start_ack = ack_total;
    cpu_rw = 1'b1; cpu_addr = 21'h000010; cpu_req = 1'b1;
    vid_addr = 21'h000020; vid_req = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL drop_hold_wait: got %b want 1", cpu_hold); end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    checks++;
    if (cpu_hold !== 1'b0) begin errors++; $display("FAIL drop_hold_release: got %b want 0", cpu_hold); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vid_ack) begin got = 1'b1; vid_req = 1'b0; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL drop_vid_ack: no ack seen"); end
    repeat (8) begin
      @(negedge clk);
      if (!sram_ce_n) ce_low++;
      if (cpu_hold) hold_hi++;
    end
    @(posedge clk); #1;
    checks++;
    if (ce_low != 0) begin errors++; $display("FAIL drop_no_cpu_access: ce_n low %0d want 0", ce_low); end
    checks++;
    if (hold_hi != 0) begin errors++; $display("FAIL drop_hold_after: got %0d want 0", hold_hi); end
    checks++;
    if (ack_total - start_ack != 1) begin
      errors++; $display("FAIL drop_ack_count: got %0d want 1", ack_total - start_ack);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_arbitration();
    test_vpu_stream();
    test_reset_mid_write();
    test_cpu_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
